apb_event_sync: RTL

Front-end conditioner for asynchronous event sources, placed directly upstream of the event/interrupt unit's `event_i`/`irq_i` inputs. Each of 32 channels is handled in four steps:
- a 2-FF synchronizer into `clk_i`;
- a programmable glitch filter;
- a per-channel edge detector, whose mode is configured over APB;
- a one-cycle registered pulse on `event_o`.

A sticky pending register records detected edges for software polling.

---
 rtl/apb_event_sync_if.sv | 28 ++
 rtl/apb_event_sync.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/apb_event_sync_if.sv
// ----------------------------------------------------------------------------
// apb_event_sync_if
// APB3 bundle for the event synchronizer register block.
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE : driven by the master
//   PRDATA/PREADY/PSLVERR            : driven by the slave
// ----------------------------------------------------------------------------
interface apb_event_sync_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_event_sync.sv
// ----------------------------------------------------------------------------
// apb_event_sync
// Conditions 32 asynchronous event sources for the event/interrupt unit:
// 2-FF synchronizer -> glitch filter -> edge detector -> registered 1-cycle
// pulse. A sticky, write-1-to-clear PEND register records every pulse.
//
// Ports
//   clk_i         : clock for all logic, APB included
//   HRESETn       : asynchronous active-low reset
//   apb           : APB slave (zero-wait, PREADY=1, PSLVERR=0)
//   async_event_i : raw asynchronous event sources
//   event_o       : conditioned one-cycle event pulses
//   pend_any_o    : OR of all PEND bits
//
// Register map (PADDR[4:2])
//   0x00 MODE_LO  RW  2-bit mode of channels 0..15
//   0x04 MODE_HI  RW  2-bit mode of channels 16..31
//   0x08 FILT     RW  filter threshold N in [FILT_W-1:0]
//   0x0C LEVEL    RO  filtered levels
//   0x10 PEND     W1C sticky edge flags
//   Mode: 00 off, 01 rising, 10 falling, 11 both
// ----------------------------------------------------------------------------
module apb_event_sync #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int FILT_W         = 4
) (
  input  logic                    clk_i,
  input  logic                    HRESETn,
  apb_event_sync_if.slave         apb,
  input  logic [31:0]             async_event_i,
  output logic [31:0]             event_o,
  output logic                    pend_any_o
);

  typedef enum logic [2:0] {
    REG_MODE_LO = 3'd0,
    REG_MODE_HI = 3'd1,
    REG_FILT    = 3'd2,
    REG_LEVEL   = 3'd3,
    REG_PEND    = 3'd4
  } reg_idx_e;

  // ---------------------------------------------------------------- APB decode
  logic [2:0] reg_idx;
  logic       wr_en;
  logic       mode_lo_we, mode_hi_we, filt_we, pend_we;

  assign reg_idx    = apb.PADDR[4:2];
  assign wr_en      = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign mode_lo_we = wr_en && (reg_idx == REG_MODE_LO);
  assign mode_hi_we = wr_en && (reg_idx == REG_MODE_HI);
  assign filt_we    = wr_en && (reg_idx == REG_FILT);
  assign pend_we    = wr_en && (reg_idx == REG_PEND);

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

  // Address bits outside [4:2] and upper FILT data bits are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{apb.PADDR[APB_ADDR_WIDTH-1:5], apb.PADDR[1:0]};

  // ----------------------------------------------------------- config registers
  logic [31:0]       mode_lo, mode_hi, pend;
  logic [FILT_W-1:0] filt_n;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      mode_lo <= '0;
      mode_hi <= '0;
      filt_n  <= '0;
    end else begin
      if (mode_lo_we) mode_lo <= apb.PWDATA;
      if (mode_hi_we) mode_hi <= apb.PWDATA;
      if (filt_we)    filt_n  <= apb.PWDATA[FILT_W-1:0];
    end
  end

  // Set has priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~(pend_we ? apb.PWDATA : 32'h0)) | event_o;
    end
  end

  assign pend_any_o = |pend;

  // ----------------------------------------------------- synchronizer + filter
  logic [31:0]       sync_ff1, sync_s, filt_lvl, filt_lvl_d;
  logic [FILT_W-1:0] cnt [32];
  logic              filt_long;
  logic [FILT_W-1:0] n_m1;

  // N of 0 or 1 means the filter is transparent (one register stage).
  assign filt_long = (filt_n > FILT_W'(1));
  assign n_m1      = filt_n - FILT_W'(1);

  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_ff1   <= '0;
      sync_s     <= '0;
      filt_lvl   <= '0;
      filt_lvl_d <= '0;
      // NOTE: the counter array is real per-channel state (not a RAM), so it
      // is reset element by element like any other flop.
      for (int c = 0; c < 32; c++) cnt[c] <= '0;
    end else begin
      sync_ff1   <= async_event_i;
      sync_s     <= sync_ff1;
      filt_lvl_d <= filt_lvl;
      for (int c = 0; c < 32; c++) begin
        if (filt_we) begin
          // Threshold change restarts every count; levels are held.
          cnt[c] <= '0;
        end else if (!filt_long) begin
          cnt[c]      <= '0;
          filt_lvl[c] <= sync_s[c];
        end else if (sync_s[c] == filt_lvl[c]) begin
          cnt[c] <= '0;
        end else if (cnt[c] == n_m1) begin
          // N consecutive differing cycles seen: accept the new level.
          cnt[c]      <= '0;
          filt_lvl[c] <= sync_s[c];
        end else begin
          cnt[c] <= cnt[c] + FILT_W'(1);
        end
      end
    end
  end

  // ------------------------------------------------------------ edge detector
  logic [63:0] mode_all;
  logic [31:0] mode_rise_en, mode_fall_en;
  logic [31:0] rise, fall, event_nxt;

  assign mode_all = {mode_hi, mode_lo};

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mode_rise_en = '0;
    mode_fall_en = '0;
    for (int c = 0; c < 32; c++) begin
      mode_rise_en[c] = mode_all[2*c];
      mode_fall_en[c] = mode_all[2*c+1];
    end
  end

  // f_d tracks f regardless of mode, so enabling a mode never fabricates an edge.
  assign rise      = filt_lvl & ~filt_lvl_d;
  assign fall      = ~filt_lvl & filt_lvl_d;
  assign event_nxt = (rise & mode_rise_en) | (fall & mode_fall_en);

  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) event_o <= '0;
    else          event_o <= event_nxt;
  end

  // ---------------------------------------------------------------- read mux
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      REG_MODE_LO: rd_mux = mode_lo;
      REG_MODE_HI: rd_mux = mode_hi;
      REG_FILT:    rd_mux = {{(32-FILT_W){1'b0}}, filt_n};
      REG_LEVEL:   rd_mux = filt_lvl;
      REG_PEND:    rd_mux = pend;
      default:     rd_mux = '0;
    endcase
  end

  assign apb.PRDATA = apb.PSEL ? rd_mux : 32'h0;

endmodule
